// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC transmit frame buffer.
//   MIN_PAYLOAD / MAX_PAYLOAD : Ethernet payload limits in bytes (11-bit)
//   IFG_CYCLES                : idle cycles inserted after the transmitter drains
//   rd_state_e                : read-side FSM states
//   wire_bytes()              : bytes actually handed to the transmitter for a payload
package mac_pkg;

  localparam logic [10:0] MIN_PAYLOAD = 11'd46;
  localparam logic [10:0] MAX_PAYLOAD = 11'd1500;
  localparam int          IFG_CYCLES  = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DRAIN,
    ST_GAP
  } rd_state_e;

  // Short payloads are padded up to the Ethernet minimum.
  function automatic logic [10:0] wire_bytes(input logic [10:0] len);
    return (len < MIN_PAYLOAD) ? MIN_PAYLOAD : len;
  endfunction

endpackage

// File: rtl/tx_buf_ram.sv
// Simple dual-port payload RAM, DEPTH x 8, one write port and one read port.
//   i_clk              : clock
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr       : read request; o_rdata updates on the next edge and
//                        holds its value while i_re is low
module tx_buf_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= mem_q[i_raddr];
  end

endmodule

// File: rtl/mac_tx_frame_buffer.sv
// Byte-wide transmit frame buffer feeding the RMII MAC transmitter.
// Stores complete payloads, drops oversize ones, replays committed frames with
// zero padding to the Ethernet minimum and enforces the inter-frame gap.
//   i_clk, i_rst_n                     : clock, async active-low reset
//   i_wr_valid/i_wr_data/i_wr_last     : payload write stream, o_wr_ready back-pressure
//   o_drop                             : one-cycle pulse when an oversize frame is discarded
//   o_valid/o_data, i_req, i_busy      : transmitter interface
//   o_frames                           : committed frames not yet started
module mac_tx_frame_buffer
  import mac_pkg::*;
#(
  parameter int DEPTH     = 2048,
  parameter int LEN_DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_wr_valid,
  input  logic [7:0]                   i_wr_data,
  input  logic                         i_wr_last,
  output logic                         o_wr_ready,
  output logic                         o_drop,
  output logic                         o_valid,
  output logic [7:0]                   o_data,
  input  logic                         i_req,
  input  logic                         i_busy,
  output logic [$clog2(LEN_DEPTH):0]   o_frames
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LEN_DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [10:0]   wr_cnt_q, wr_cnt_d, wr_cnt_inc;
  logic          discard_q, discard_d, drop_q, drop_d;
  logic          wr_accept, ram_we, push, pop, len_full;
  logic [10:0]   len_mem_q [LEN_DEPTH];
  logic [LW-1:0] len_wi_q, len_ri_q;
  logic [LW:0]   frames_q, frames_d;

  rd_state_e     state_q, state_d;
  logic [10:0]   sent_q, sent_d, len_q, len_d;
  logic          valid_q, valid_d, busy_seen_q, busy_seen_d;
  logic [5:0]    gap_q, gap_d;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [7:0]    ram_rdata;

  // Uncommitted bytes also occupy RAM, so fullness is judged on wr_ptr.
  assign len_full   = (frames_q == (LW+1)'(LEN_DEPTH));
  assign o_wr_ready = (AW'(wr_ptr_q + 1'b1) != rd_ptr_q) && !len_full;
  assign wr_accept  = i_wr_valid && o_wr_ready;
  assign wr_cnt_inc = wr_cnt_q + 11'd1;
  assign pop        = (state_q == ST_LOAD);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_cnt_d     = wr_cnt_q;
    discard_d    = discard_q;
    drop_d       = 1'b0;
    push         = 1'b0;
    ram_we       = 1'b0;
    if (wr_accept) begin
      if (discard_q) begin
        // Swallow the tail of a dropped frame up to its last byte.
        if (i_wr_last) discard_d = 1'b0;
      end else if (wr_cnt_inc > MAX_PAYLOAD) begin
        // Oversize: rewind to the last commit point; this byte is discarded too.
        wr_ptr_d  = commit_ptr_q;
        wr_cnt_d  = '0;
        drop_d    = 1'b1;
        discard_d = !i_wr_last;
      end else begin
        ram_we   = 1'b1;
        wr_ptr_d = AW'(wr_ptr_q + 1'b1);
        if (i_wr_last) begin
          push         = 1'b1;
          commit_ptr_d = AW'(wr_ptr_q + 1'b1);
          wr_cnt_d     = '0;
        end else begin
          wr_cnt_d = wr_cnt_inc;
        end
      end
    end
  end

  always_comb begin
    case ({push, pop})
      2'b10:   frames_d = frames_q + 1'b1;
      2'b01:   frames_d = frames_q - 1'b1;
      default: frames_d = frames_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) len_mem_q[len_wi_q] <= wr_cnt_inc;
  end

  always_comb begin
    state_d     = state_q;
    sent_d      = sent_q;
    len_d       = len_q;
    valid_d     = valid_q;
    busy_seen_d = busy_seen_q;
    gap_d       = gap_q;
    rd_ptr_d    = rd_ptr_q;
    ram_re      = 1'b0;
    ram_raddr   = rd_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if ((frames_q != '0) && !i_busy) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ram_re  = 1'b1;
        len_d   = len_mem_q[len_ri_q];
        sent_d  = '0;
        valid_d = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (i_req) begin
          sent_d = sent_q + 11'd1;
          // Prefetch the next payload byte; once past the payload, o_data pads with zero.
          if (sent_q < len_q) begin
            rd_ptr_d  = AW'(rd_ptr_q + 1'b1);
            ram_re    = 1'b1;
            ram_raddr = AW'(rd_ptr_q + 1'b1);
          end
          if (sent_d == wire_bytes(len_q)) begin
            valid_d     = 1'b0;
            busy_seen_d = 1'b0;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Busy may already be high on entry; either way wait for its falling edge.
        if (i_busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == 6'(IFG_CYCLES - 1)) state_d = ST_IDLE;
        else                              gap_d   = gap_q + 6'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      wr_cnt_q     <= '0;
      discard_q    <= 1'b0;
      drop_q       <= 1'b0;
      len_wi_q     <= '0;
      len_ri_q     <= '0;
      frames_q     <= '0;
      state_q      <= ST_IDLE;
      sent_q       <= '0;
      len_q        <= '0;
      valid_q      <= 1'b0;
      busy_seen_q  <= 1'b0;
      gap_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_cnt_q     <= wr_cnt_d;
      discard_q    <= discard_d;
      drop_q       <= drop_d;
      if (push) len_wi_q <= len_wi_q + 1'b1;
      if (pop)  len_ri_q <= len_ri_q + 1'b1;
      frames_q     <= frames_d;
      state_q      <= state_d;
      sent_q       <= sent_d;
      len_q        <= len_d;
      valid_q      <= valid_d;
      busy_seen_q  <= busy_seen_d;
      gap_q        <= gap_d;
    end
  end

  tx_buf_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .i_clk  (i_clk),
    .i_we   (ram_we),
    .i_waddr(wr_ptr_q),
    .i_wdata(i_wr_data),
    .i_re   (ram_re),
    .i_raddr(ram_raddr),
    .o_rdata(ram_rdata)
  );

  // Gating on valid_q makes o_data fall with the asynchronous reset.
  assign o_data   = (valid_q && (sent_q < len_q)) ? ram_rdata : 8'h00;
  assign o_valid  = valid_q;
  assign o_drop   = drop_q;
  assign o_frames = frames_q;

endmodule

// File: tb/tb_mac_tx_frame_buffer.sv
module tb_mac_tx_frame_buffer;

  localparam int MINP = 46;
  localparam int MAXP = 1500;
  localparam int IFG  = 48;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, wr_last, wr_ready, drop, valid, req, busy;
  logic [7:0] wr_data, data;
  logic [2:0] frames;

  always #10 clk = ~clk;

  mac_tx_frame_buffer #(.DEPTH(2048), .LEN_DEPTH(4)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_wr_valid(wr_valid),
    .i_wr_data (wr_data),
    .i_wr_last (wr_last),
    .o_wr_ready(wr_ready),
    .o_drop    (drop),
    .o_valid   (valid),
    .o_data    (data),
    .i_req     (req),
    .i_busy    (busy),
    .o_frames  (frames)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  byte unsigned exp_bytes[$];
  int           exp_len[$];
  int           commits_ref = 0, rises_ref = 0, drop_seen = 0, fill_acc = 0;
  int           cyc = 0;
  bit           frames_chk_en = 0, fill_blocked = 0;

  // transmitter model state
  bit tx_stall = 0, busy_force = 0, in_frame = 0, have_fall = 0, req_prev = 0, want_first_req = 0;
  int req_period = 4, tail_cfg = 20, nreq = 0, ph = 0, tail_left = 0, tail_used = 0;
  int fall_cyc = 0, first_req_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s: got %0d, expected at least %0d (cycle %0d)", name, act, min, cyc);
    end
  endtask

  // Transmitter model: consumes a byte every req_period cycles while o_valid,
  // holds busy through the frame and for a tail afterwards.
  initial begin
    req = 1'b0;
    busy = 1'b0;
    forever begin
      @(negedge clk);
      req_prev = req;
      req = 1'b0;
      if (!rst_n) begin
        in_frame = 0; tail_left = 0; have_fall = 0; ph = 0; busy = 1'b0;
        continue;
      end
      if (valid) begin
        if (!in_frame) begin
          in_frame = 1; nreq = 0; ph = 0;
          if (have_fall) check_ge("ifg_low_cycles", cyc - fall_cyc, IFG + tail_used);
        end
        busy = 1'b1;
        if (!tx_stall) begin
          if (ph >= req_period - 1) begin
            ph = 0;
            req = 1'b1;
            nreq++;
            if (want_first_req) begin want_first_req = 0; first_req_cyc = cyc; end
            if (exp_bytes.size() == 0) check("tx_byte_unexpected", 1, 0);
            else check("tx_byte", data, exp_bytes.pop_front());
          end else begin
            ph++;
          end
        end
      end else begin
        if (in_frame) begin
          in_frame = 0;
          check("valid_fall_after_last_req", req_prev, 1);
          if (exp_len.size() == 0) check("tx_frame_unexpected", 1, 0);
          else check("tx_frame_req_count", nreq, exp_len.pop_front());
          fall_cyc  = cyc;
          have_fall = 1;
          tail_used = (tail_cfg == 0) ? int'($urandom_range(2, 30)) : tail_cfg;
          tail_left = tail_used;
        end
        if (tail_left > 0) begin tail_left--; busy = 1'b1; end
        else busy = busy_force;
      end
    end
  end

  // Frame-count monitor: committed minus started frames.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin prev_valid = 1'b0; continue; end
      if (valid && !prev_valid) rises_ref++;
      prev_valid = valid;
      if (drop) drop_seen++;
      if (frames_chk_en) check("o_frames", frames, commits_ref - rises_ref);
    end
  end

  task automatic write_frame(input int n, input bit ramp, input bit gaps, input bit fill_chk);
    byte unsigned pl[$];
    int  i, waitc;
    bit  drop_exp, resume_pending;
    for (int k = 0; k < n; k++) pl.push_back(ramp ? k[7:0] : 8'($urandom));
    if (n <= MAXP) begin
      for (int k = 0; k < n; k++) exp_bytes.push_back(pl[k]);
      for (int k = n; k < MINP; k++) exp_bytes.push_back(8'h00);
      exp_len.push_back((n < MINP) ? MINP : n);
    end
    i = 0; waitc = 0; drop_exp = 0; resume_pending = 0;
    while (i < n) begin
      @(negedge clk);
      check("o_drop", drop, drop_exp);
      drop_exp = 0;
      if (resume_pending && wr_ready) begin
        check("ready_resume_cycle", cyc, first_req_cyc + 1);
        resume_pending = 0;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0;
        continue;
      end
      wr_valid = 1'b1;
      wr_data  = pl[i];
      wr_last  = (i == n - 1);
      if (wr_ready) begin
        if (i + 1 == MAXP + 1) drop_exp = 1;
        if (wr_last && n <= MAXP) commits_ref++;
        fill_acc++;
        i++;
        waitc = 0;
      end else begin
        if (fill_chk && !fill_blocked) begin
          fill_blocked = 1;
          check("fill_level_at_block", fill_acc, 2047);
          want_first_req = 1;
          tx_stall = 0;
          resume_pending = 1;
        end
        waitc++;
        if (waitc > 20000) begin
          check("write_stall_timeout", 1, 0);
          break;
        end
      end
    end
    @(negedge clk);
    check("o_drop", drop, drop_exp);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 40000; c++) begin
      @(negedge clk);
      if (exp_len.size() == 0 && !valid && !in_frame && tail_left == 0 && frames == 0) return;
    end
    check("wait_idle_timeout", 1, 0);
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; wr_last = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_o_valid", valid, 0);
    check("reset_o_data", data, 0);
    check("reset_o_drop", drop, 0);
    check("reset_o_frames", frames, 0);
    check("reset_o_wr_ready", wr_ready, 1);
    rst_n = 1'b1;
    frames_chk_en = 1;

    // 64-byte ramp
    write_frame(64, 1, 0, 0);
    wait_idle();
    check("drop_count_ramp", drop_seen, 0);

    // short frame padded to 46
    write_frame(10, 1, 0, 0);
    wait_idle();

    // three back-to-back frames queued while the transmitter is busy
    busy_force = 1;
    for (int f = 0; f < 3; f++) write_frame(60, 0, 0, 0);
    @(negedge clk);
    check("frames_queued", frames, 3);
    busy_force = 0;
    wait_idle();

    // oversize frame dropped, following frame intact
    drop_seen = 0;
    write_frame(1600, 0, 0, 0);
    write_frame(50, 0, 0, 0);
    wait_idle();
    check("drop_count_oversize", drop_seen, 1);

    // fill across the pointer wrap with the sender stalled
    tx_stall = 1; fill_acc = 0; fill_blocked = 0;
    write_frame(1500, 0, 0, 0);
    write_frame(1500, 0, 0, 1);
    check("fill_blocked", fill_blocked, 1);
    tx_stall = 0;
    wait_idle();

    // randomized frames, write gaps, request periods and busy tails
    tail_cfg = 0;
    for (int f = 0; f < 10; f++) begin
      req_period = $urandom_range(2, 6);
      write_frame($urandom_range(1, 120), 0, 1, 0);
    end
    wait_idle();

    // asynchronous reset in the middle of a frame
    req_period = 4; tail_cfg = 20;
    write_frame(100, 0, 0, 0);
    write_frame(80, 0, 0, 0);
    for (int c = 0; c < 5000 && !(in_frame && nreq >= 5); c++) @(negedge clk);
    check("reached_send_before_reset", in_frame && nreq >= 5, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_bytes.delete();
    exp_len.delete();
    commits_ref = 0;
    rises_ref = 0;
    #1;
    check("async_reset_o_valid", valid, 0);
    check("async_reset_o_data", data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_o_frames", frames, 0);
    check("post_reset_o_wr_ready", wr_ready, 1);
    write_frame(30, 0, 0, 0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_tx_frame_buffer.md
# mac_tx_frame_buffer

Byte-wide frame buffer directly upstream of the RMII MAC transmitter. A user source writes complete payloads into it. The buffer replays each stored frame to the transmitter's `i_valid`/`i_data`/`o_req` interface and pads short payloads to the Ethernet minimum. It enforces the inter-frame gap and the maximum payload, so the transmitter always sees legal, back-to-back-safe frames.

## Interface
Parameters:
- `DEPTH` — default 2048; payload RAM size in bytes, power of two, ≥ `MAX_PAYLOAD`+1.
- `LEN_DEPTH` — default 4; number of committed frames held, power of two.

Ports:
- `i_clk` — input, 1. Single clock (50 MHz RMII domain).
- `i_rst_n` — input, 1. Asynchronous reset, active-low.
- `i_wr_valid` — input, 1. Write byte valid.
- `i_wr_data` — input, 8. Payload byte.
- `i_wr_last` — input, 1. Marks the final byte of the payload; qualified by `i_wr_valid`.
- `o_wr_ready` — output, 1. Buffer accepts a byte this cycle.
- `o_drop` — output, 1. One-cycle pulse: the frame being written was discarded (oversize).
- `o_valid` — output, 1. Drives the transmitter's `i_valid`. A rising edge starts a frame.
- `o_data` — output, 8. Drives the transmitter's `i_data`.
- `i_req` — input, 1. Transmitter's `o_req`. One-cycle pulse per byte consumed.
- `i_busy` — input, 1. Transmitter's `o_busy`.
- `o_frames` — output, $clog2(LEN_DEPTH)+1. Count of committed, unsent frames.

## Operation
- Write side:
  - A byte is accepted when `i_wr_valid & o_wr_ready`, stored at `wr_ptr`, and `wr_ptr` increments (mod `DEPTH`).
  - `o_wr_ready = !(wr_ptr+1 == rd_ptr) & !len_full`.
  - An accepted byte with `i_wr_last` commits the frame: length (1..1500) is pushed to the length FIFO and `commit_ptr ← wr_ptr+1`.
  - When the byte count of the current frame reaches 1501 without `last`: `wr_ptr ← commit_ptr`, `o_drop` pulses, and the remaining bytes up to and including `last` are accepted and discarded.
- Read FSM:
  - `IDLE`: if `o_frames≠0 & !i_busy` → `LOAD`. In `LOAD`, pop the length, issue a RAM read of `rd_ptr`, and set `sent ← 0`.
  - `LOAD` → `SEND` after 1 cycle. `o_valid ← 1`, `o_data ←` RAM data.
  - `SEND`: on `i_req`, `sent++`.
    - While `sent < len`: `rd_ptr++` and `o_data ←` next byte, valid 1 cycle after `i_req`.
    - Once `sent ≥ len`: `o_data ← 8'h00` (padding).
    - When `sent` reaches `max(len,46)` on an `i_req`: `o_valid ← 0` → `DRAIN`.
  - `DRAIN`: wait for `i_busy` high, then low → `GAP`. If `i_busy` is already high on entry, only wait for low.
  - `GAP`: count `IFG_CYCLES` (48) cycles → `IDLE`.
- `o_data` is held stable between `i_req` pulses; `i_req` outside `SEND` is ignored.
- `i_req` coinciding with a write commit: both are processed; `o_frames` nets to unchanged if a pop and push land in the same cycle.
- Reset values: `o_valid=0`, `o_data=8'h00`, `o_drop=0`, `o_frames=0`, `o_wr_ready=1`; all pointers 0; FSM `IDLE`.
- Reset mid-frame aborts both sides. Buffered frames are lost and `o_valid` falls immediately (async).

## Timing
- Write to commit: the committed frame is visible in `o_frames` on the cycle after the `last` byte is accepted.
- Commit to `o_valid` rise: 2 cycles minimum (`IDLE`→`LOAD`→`SEND`), with transmitter idle.
- `i_req` to next `o_data`: 1 cycle. The transmitter samples ≥3 cycles later.
- `o_valid` fall: cycle after the final `i_req`.
- Frame-to-frame: `o_valid` low for ≥ transmitter drain + 48 cycles.
- Width rules:
  - `sent` and `len` are 11 bits.
  - Padding compare uses the 11-bit constant `MIN_PAYLOAD=46`.
  - Pointers are `$clog2(DEPTH)` bits with natural wrap.

## Structure
- `mac_pkg`: `MIN_PAYLOAD=46`, `MAX_PAYLOAD=1500`, `IFG_CYCLES=48`, and the read FSM state enum type.
- One sub-module, `tx_buf_ram`: simple dual-port, 1 write / 1 read port, registered read (1-cycle latency), `DEPTH`×8.
- Length FIFO: inline register array of `LEN_DEPTH`×11 bits.

## Test plan
- 64-byte ramp payload `0x00..0x3F`, transmitter model pulsing `i_req` every 4 cycles → 64 bytes in order, `o_valid` low after the 64th `i_req`, `o_drop` never set.
- 10-byte payload → bytes `0..9`, then 36×`0x00`; `o_valid` drops after exactly 46 `i_req`.
- Three back-to-back 60-byte frames, busy model 20 cycles per frame tail → `o_valid` low ≥48 cycles between frames; `o_frames` goes 3,2,1,0.
- 1600-byte write without `last` until byte 1600 → `o_drop` pulses at byte 1501; `o_frames` stays 0; a following 50-byte frame is sent intact.
- Fill past `DEPTH` (two 1500-byte frames, sender stalled) → `o_wr_ready` low at 2047 buffered bytes; it resumes 1 cycle after the first `i_req`; no data corruption across pointer wrap.
- Assert `i_rst_n=0` mid-`SEND` → `o_valid`/`o_data` go to 0 asynchronously; after release, `o_frames=0` and `o_wr_ready=1`.
